// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: widths, FSM state
// encoding, fixed latency and the product-fit overflow rule.
package mul_seq_pkg;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned ITER    = 16;
   localparam int unsigned LATENCY = 21;

   typedef enum logic [2:0] {
      IDLE,
      NEGA,
      NEGB,
      RUN,
      FIXLO,
      FIXHI,
      DONE
   } state_e;

   // Signed results fit 16 bits only when the upper 17 bits are pure sign extension.
   function automatic logic prodOverflow(input logic isSigned,
                                         input logic [2*WIDTH-1:0] p);
      logic allOnes;
      logic allZeros;
      allOnes  = &p[2*WIDTH-1:WIDTH-1];
      allZeros = ~|p[2*WIDTH-1:WIDTH-1];
      if (isSigned) begin
         return !(allOnes || allZeros);
      end
      return |p[2*WIDTH-1:WIDTH];
   endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Issue/result handshake between the execute stage and the multiplier.
interface mul_seq_if;
   import mul_seq_pkg::*;

   logic                 start;
   logic                 sign;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   prod;
   logic                 overflow;

   modport master (
      output start, sign, a, b,
      input  busy, done, prod, overflow
   );

   modport slave (
      input  start, sign, a, b,
      output busy, done, prod, overflow
   );

endinterface

// File: rtl/mul_seq_add.sv
// The team's 16-bit ripple adder with carry-in, carry-out and an overflow flag
// whose meaning follows the sign_i mode.
module add (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   input  logic        sign_i,
   output logic [15:0] sum_o,
   output logic        cout_o,
   output logic        ovf_o
);

   logic [16:0] full;

   always_comb begin
      full   = {1'b0, a_i} + {1'b0, b_i} + {16'd0, cin_i};
      sum_o  = full[15:0];
      cout_o = full[16];
      ovf_o  = sign_i ? ((a_i[15] == b_i[15]) && (full[15] != a_i[15])) : full[16];
   end

endmodule

// File: rtl/mul_seq.sv
// Fixed-latency 16x16 signed/unsigned multiplier: magnitudes are formed, shift-add
// accumulated and sign-corrected, all through one time-shared adder.
module mul_seq
   import mul_seq_pkg::*;
(
   input logic      clk,
   input logic      rst_n,
   mul_seq_if.slave bus
);

   state_e               state_q;
   logic [WIDTH-1:0]     opA_q;
   logic [WIDTH-1:0]     opB_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH-1:0]     accHi_q;
   logic [WIDTH-1:0]     accLo_q;
   logic                 sign_q;
   logic                 neg_q;
   logic                 carry_q;
   logic [3:0]           cnt_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 overflow_q;
   logic [2*WIDTH-1:0]   prod_q;

   logic [WIDTH-1:0]     addA;
   logic [WIDTH-1:0]     addB;
   logic [WIDTH-1:0]     addSum;
   logic                 addCin;
   logic                 addCout;
   logic                 add_ovf_unused;

   logic                 accept;
   logic                 negA;
   logic                 negB;
   logic [2*WIDTH-1:0]   prodFinal;

   assign accept    = bus.start && ((state_q == IDLE) || (state_q == DONE));
   assign negA      = sign_q & opA_q[WIDTH-1];
   assign negB      = sign_q & opB_q[WIDTH-1];
   assign prodFinal = {addSum, accLo_q};

   // Two's-complement negation is ~x + 1, so the carry-in doubles as the "negate" select.
   always_comb begin
      addA   = '0;
      addB   = '0;
      addCin = 1'b0;
      case (state_q)
         NEGA: begin
            addA   = negA ? ~opA_q : opA_q;
            addCin = negA;
         end
         NEGB: begin
            addA   = negB ? ~opB_q : opB_q;
            addCin = negB;
         end
         RUN: begin
            addA = accHi_q;
            addB = accLo_q[0] ? mcand_q : '0;
         end
         FIXLO: begin
            addA   = neg_q ? ~accLo_q : accLo_q;
            addCin = neg_q;
         end
         FIXHI: begin
            addA   = neg_q ? ~accHi_q : accHi_q;
            addCin = neg_q & carry_q;
         end
         default: begin
            addA   = '0;
            addB   = '0;
            addCin = 1'b0;
         end
      endcase
   end

   add uAdd (
      .a_i    (addA),
      .b_i    (addB),
      .cin_i  (addCin),
      .sign_i (1'b0),
      .sum_o  (addSum),
      .cout_o (addCout),
      .ovf_o  (add_ovf_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         opA_q      <= '0;
         opB_q      <= '0;
         mcand_q    <= '0;
         accHi_q    <= '0;
         accLo_q    <= '0;
         sign_q     <= 1'b0;
         neg_q      <= 1'b0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         prod_q     <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  opA_q   <= bus.a;
                  opB_q   <= bus.b;
                  sign_q  <= bus.sign;
                  neg_q   <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  busy_q  <= 1'b1;
                  state_q <= NEGA;
               end else begin
                  state_q <= IDLE;
               end
            end
            NEGA: begin
               mcand_q <= addSum;
               state_q <= NEGB;
            end
            NEGB: begin
               accLo_q <= addSum;
               accHi_q <= '0;
               cnt_q   <= '0;
               state_q <= RUN;
            end
            // The multiplier shifts out of accLo as the partial product shifts in from the top.
            RUN: begin
               accHi_q <= {addCout, addSum[WIDTH-1:1]};
               accLo_q <= {addSum[0], accLo_q[WIDTH-1:1]};
               cnt_q   <= cnt_q + 4'd1;
               if (cnt_q == 4'(ITER - 1)) begin
                  state_q <= FIXLO;
               end
            end
            FIXLO: begin
               accLo_q <= addSum;
               carry_q <= addCout;
               state_q <= FIXHI;
            end
            FIXHI: begin
               prod_q     <= prodFinal;
               overflow_q <= prodOverflow(sign_q, prodFinal);
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               state_q    <= DONE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.prod     = prod_q;
   assign bus.overflow = overflow_q;

`ifndef SYNTHESIS
   logic [5:0] age_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q <= '0;
      end else if (accept) begin
         age_q <= 6'd1;
      end else if (done_q) begin
         age_q <= '0;
      end else if (age_q != '0) begin
         age_q <= age_q + 6'd1;
      end
   end

   // done must appear exactly LATENCY edges after the accepting edge, never otherwise.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (done_q == (age_q == 6'(LATENCY)))
            else $error("mul_seq: done pulse not at fixed latency");
         assert (!(busy_q && done_q))
            else $error("mul_seq: busy and done both high");
      end
   end
`endif

endmodule
